fp_sum_seq: RTL and testbench

//  Streaming FP32 reduction sequencer; initiator side of the fp_add in_valid/out_valid interface.

---
 rtl/fp_pkg.sv | 18 +
 rtl/fp_wait_timer.sv | 37 +++
 rtl/fp_sum_seq.sv | 164 ++++++++++++++++
 tb/tb_fp_sum_seq.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared FP32 definitions and the reduction sequencer state encoding.
// Imported by fp_add and by the fp_sum_seq block.
package fp_pkg;

  localparam int FP32_W    = 32;
  localparam int FP_SIGN_W = 1;
  localparam int FP_EXP_W  = 8;
  localparam int FP_MANT_W = 23;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    ISSUE,
    WAIT,
    DONE
  } sum_state_e;

endpackage

// File: rtl/fp_wait_timer.sv
// Watchdog counter for one outstanding fp_add operation.
// Asserts expire during the last enabled cycle of a MAX_WAIT-cycle window.
module fp_wait_timer #(
  parameter int MAX_WAIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = $clog2(MAX_WAIT + 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(MAX_WAIT - 1);

  logic [TW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != LAST_CNT)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire = enable && (count_q == LAST_CNT);

endmodule

// File: rtl/fp_sum_seq.sv
// Streaming FP32 vector reduction: drives an external fp_add one operation at a time,
// feeding the running sum back, and presents the total with element count and timeout flag.
module fp_sum_seq
  import fp_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [FP32_W-1:0] s_data,
  input  logic              s_last,
  output logic              add_valid,
  output logic [FP32_W-1:0] add_a,
  output logic [FP32_W-1:0] add_b,
  input  logic              add_out_valid,
  input  logic [FP32_W-1:0] add_result,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [FP32_W-1:0] m_data,
  output logic [CNT_W-1:0]  m_count,
  output logic              m_err
);

  sum_state_e        state_q, state_d;
  logic [FP32_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              last_q, last_d;
  logic              err_q, err_d;
  logic              s_ready_q, s_ready_d;
  logic              add_valid_q, add_valid_d;
  logic [FP32_W-1:0] add_a_q, add_a_d;
  logic [FP32_W-1:0] add_b_q, add_b_d;
  logic              m_valid_q, m_valid_d;
  logic [FP32_W-1:0] m_data_q, m_data_d;
  logic [CNT_W-1:0]  m_count_q, m_count_d;
  logic              m_err_q, m_err_d;

  logic timer_clear, timer_enable, timer_expire;
  logic s_xfer, m_xfer;

  assign s_xfer       = s_valid && s_ready_q;
  assign m_xfer       = m_valid_q && m_ready;
  assign timer_clear  = (state_q == ISSUE);
  assign timer_enable = (state_q == WAIT);

  fp_wait_timer #(
    .MAX_WAIT (MAX_WAIT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
    err_d     = err_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    m_data_d  = m_data_q;
    m_count_d = m_count_q;

    case (state_q)
      IDLE: begin
        // The first element seeds the sum directly; no add is spent on it.
        if (s_xfer) begin
          acc_d   = s_data;
          cnt_d   = CNT_W'(1);
          last_d  = s_last;
          state_d = s_last ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (s_xfer) begin
          add_a_d = acc_q;
          add_b_d = s_data;
          last_d  = s_last;
          cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A result arriving in the final window cycle still wins over the timeout.
        if (add_out_valid) begin
          acc_d   = add_result;
          state_d = last_q ? DONE : ACCUM;
        end else if (timer_expire) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (m_xfer) begin
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    s_ready_d   = (state_d == IDLE) || (state_d == ACCUM);
    add_valid_d = (state_d == ISSUE);
    m_valid_d   = (state_d == DONE);
    m_err_d     = (state_d == DONE) ? err_d : 1'b0;
    if (state_d == DONE) begin
      m_data_d  = acc_d;
      m_count_d = cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      err_q       <= 1'b0;
      s_ready_q   <= 1'b1;
      add_valid_q <= 1'b0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      m_count_q   <= '0;
      m_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      err_q       <= err_d;
      s_ready_q   <= s_ready_d;
      add_valid_q <= add_valid_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      m_count_q   <= m_count_d;
      m_err_q     <= m_err_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign add_valid = add_valid_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_count   = m_count_q;
  assign m_err     = m_err_q;

endmodule

// File: tb/tb_fp_sum_seq.sv
// Directed scoreboard bench for fp_sum_seq with a behavioural fp_add stub
// (positive-normal adder, configurable latency, stall and spurious-pulse modes).
module tb_fp_sum_seq;

  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              s_valid;
  logic              s_ready;
  logic [31:0]       s_data;
  logic              s_last;
  logic              add_valid;
  logic [31:0]       add_a;
  logic [31:0]       add_b;
  logic              add_out_valid;
  logic [31:0]       add_result;
  logic              m_valid;
  logic              m_ready;
  logic [31:0]       m_data;
  logic [CNT_W-1:0]  m_count;
  logic              m_err;

  typedef struct {
    logic [31:0] data;
    logic [31:0] count;
    logic        err;
    int          adds;
  } exp_t;

  exp_t        sb[$];
  int          check_count = 0;
  int          error_count = 0;
  int          cycle_cnt = 0;
  int          issue_cycle = 0;
  int          add_pulses = 0;
  int          adds_seen = 0;
  int          add_latency = 2;
  bit          add_stall = 1'b0;
  bit          check_hold = 1'b1;
  bit          spur_req = 1'b0;
  bit          spur_seen = 1'b0;
  logic [31:0] stub_a, stub_b;
  logic [31:0] elems[16];

  fp_sum_seq #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .s_last        (s_last),
    .add_valid     (add_valid),
    .add_a         (add_a),
    .add_b         (add_b),
    .add_out_valid (add_out_valid),
    .add_result    (add_result),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data),
    .m_count       (m_count),
    .m_err         (m_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_count++;
    assert (obs === exp) else begin
      error_count++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Exact for the positive normal operands used here; truncates otherwise.
  function automatic logic [31:0] fp_add_pos(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]  ea, eb, et;
    logic [24:0] ma, mb, mt, sum;
    ea = a[30:23]; eb = b[30:23];
    ma = {2'b01, a[22:0]}; mb = {2'b01, b[22:0]};
    if (ea < eb) begin
      et = ea; ea = eb; eb = et;
      mt = ma; ma = mb; mb = mt;
    end
    mb = mb >> (ea - eb);
    sum = ma + mb;
    if (sum[24]) begin
      sum = sum >> 1;
      ea  = ea + 8'd1;
    end
    return {1'b0, ea, sum[22:0]};
  endfunction

  initial begin
    add_out_valid = 1'b0;
    add_result    = '0;
    forever begin
      @(negedge clk);
      if (spur_req != spur_seen) begin
        spur_seen     = spur_req;
        add_out_valid = 1'b1;
        add_result    = 32'h7F000000;
        @(negedge clk);
        add_out_valid = 1'b0;
      end else if (add_valid) begin
        add_pulses++;
        issue_cycle = cycle_cnt;
        stub_a = add_a;
        stub_b = add_b;
        if (!add_stall) begin
          for (int i = 0; i < add_latency; i++) begin
            @(negedge clk);
            if (check_hold) begin
              check_output("add_valid_pulse", {31'b0, add_valid}, 32'd0);
              check_output("add_a_hold", add_a, stub_a);
              check_output("add_b_hold", add_b, stub_b);
            end
          end
          add_out_valid = 1'b1;
          add_result    = fp_add_pos(stub_a, stub_b);
          @(negedge clk);
          add_out_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid && m_ready) begin
      check_count++;
      assert (sb.size() != 0) else begin
        error_count++;
        $error("[TB] FAIL unexpected_result observed=m_valid expected=no_output");
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check_output("m_data", m_data, e.data);
        check_output("m_count", {29'b0, m_count}, e.count);
        check_output("m_err", {31'b0, m_err}, {31'b0, e.err});
        check_output("add_issue_count", add_pulses - adds_seen, e.adds);
        adds_seen = add_pulses;
      end
    end
  end

  task automatic push_expect(input logic [31:0] data, input int count, input logic err, input int adds);
    exp_t e;
    e.data = data; e.count = count; e.err = err; e.adds = adds;
    sb.push_back(e);
  endtask

  task automatic send_elem(input logic [31:0] data, input logic last);
    int n = 0;
    s_valid = 1'b1; s_data = data; s_last = last;
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("s_ready_wait", {31'b0, s_ready}, 32'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic apply_stimulus(input int n, input logic [31:0] data, input int count,
                                input logic err, input int adds, input bit push);
    if (push) push_expect(data, count, err, adds);
    for (int i = 0; i < n; i++) send_elem(elems[i], (i == n - 1));
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check_output("result_wait", sb.size(), 32'd0);
  endtask

  task automatic wait_m_valid();
    int n = 0;
    while (!m_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check_output("m_valid_wait", {31'b0, m_valid}, 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_s_ready"}, {31'b0, s_ready}, 32'd1);
    check_output({tag, "_add_valid"}, {31'b0, add_valid}, 32'd0);
    check_output({tag, "_m_valid"}, {31'b0, m_valid}, 32'd0);
    check_output({tag, "_m_err"}, {31'b0, m_err}, 32'd0);
    check_output({tag, "_add_a"}, add_a, 32'd0);
    check_output({tag, "_add_b"}, add_b, 32'd0);
    check_output({tag, "_m_data"}, m_data, 32'd0);
    check_output({tag, "_m_count"}, {29'b0, m_count}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);

    $display("[TB] two-element vector");
    elems[0] = 32'h3F000000; elems[1] = 32'h3E800000;
    apply_stimulus(2, 32'h3F400000, 2, 1'b0, 1, 1'b1);
    wait_done();

    $display("[TB] three-element vector");
    elems[0] = 32'h3FC00000; elems[1] = 32'h40100000; elems[2] = 32'h3E800000;
    apply_stimulus(3, 32'h40800000, 3, 1'b0, 2, 1'b1);
    wait_done();

    $display("[TB] single-element vector");
    elems[0] = 32'h40B80000;
    apply_stimulus(1, 32'h40B80000, 1, 1'b0, 0, 1'b1);
    check_output("single_latency", {31'b0, m_valid}, 32'd1);
    wait_done();

    $display("[TB] output back-pressure");
    m_ready = 1'b0;
    elems[0] = 32'h40000000; elems[1] = 32'h40400000;
    apply_stimulus(2, 32'h40A00000, 2, 1'b0, 1, 1'b1);
    wait_m_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp_m_valid", {31'b0, m_valid}, 32'd1);
      check_output("bp_m_data", m_data, 32'h40A00000);
      check_output("bp_s_ready", {31'b0, s_ready}, 32'd0);
    end
    @(posedge clk); #1 m_ready = 1'b1;
    wait_done();
    @(negedge clk);
    check_output("bp_release_s_ready", {31'b0, s_ready}, 32'd1);
    check_output("bp_release_m_valid", {31'b0, m_valid}, 32'd0);

    $display("[TB] adder timeout");
    add_stall = 1'b1;
    elems[0] = 32'h3F000000; elems[1] = 32'h3E800000;
    apply_stimulus(2, 32'h3F000000, 2, 1'b1, 1, 1'b1);
    wait_m_valid();
    check_output("timeout_latency", cycle_cnt - issue_cycle, 32'd17);
    wait_done();
    add_stall = 1'b0;
    elems[0] = 32'h3F800000; elems[1] = 32'h3F800000;
    apply_stimulus(2, 32'h40000000, 2, 1'b0, 1, 1'b1);
    wait_done();

    $display("[TB] spurious adder result outside WAIT");
    push_expect(32'h3F400000, 2, 1'b0, 1);
    send_elem(32'h3F000000, 1'b0);
    spur_req = ~spur_req;
    repeat (3) @(negedge clk);
    send_elem(32'h3E800000, 1'b1);
    wait_done();

    $display("[TB] element counter saturation");
    for (int i = 0; i < 9; i++) elems[i] = 32'h3F800000;
    apply_stimulus(9, 32'h41100000, 7, 1'b0, 8, 1'b1);
    wait_done();

    $display("[TB] reset during WAIT");
    check_hold  = 1'b0;
    add_latency = 6;
    elems[0] = 32'h3F800000; elems[1] = 32'h40000000;
    apply_stimulus(2, 32'h0, 0, 1'b0, 0, 1'b0);
    @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_reset_values("midrst");
    repeat (8) @(negedge clk);
    check_reset_values("post_stale");
    check_hold  = 1'b1;
    add_latency = 2;
    // The aborted vector's single issue is counted against the next result.
    elems[0] = 32'h40400000;
    apply_stimulus(1, 32'h40400000, 1, 1'b0, 1, 1'b1);
    wait_done();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
